// File: rtl/bcd_edit_pkg.sv
// Shared types, constants and BCD digit arithmetic for the field editor.
package bcd_edit_pkg;

    localparam logic [4:0] BLANK_CODE = 5'd31;
    localparam int         MAX_DIG    = 8;

    typedef logic [3:0]           bcd_digit_t;
    typedef logic [4*MAX_DIG-1:0] bcd_vec_t;
    // Bit 4*MAX_DIG is the carry (add) or borrow (subtract) out of the top digit.
    typedef logic [4*MAX_DIG:0]   bcd_ext_t;

    function automatic bcd_digit_t bcd_inc_wrap(input bcd_digit_t d, input bcd_digit_t max_d);
        return (d < max_d) ? d + 4'd1 : 4'd0;
    endfunction

    function automatic bcd_digit_t bcd_dec_wrap(input bcd_digit_t d, input bcd_digit_t max_d);
        return (d != 4'd0) ? d - 4'd1 : max_d;
    endfunction

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input bcd_digit_t max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    // Largest legal value of an ndig-digit field, zero-padded to MAX_DIG digits.
    function automatic bcd_vec_t bcd_max(input int ndig, input int top_max);
        bcd_vec_t r;
        r = '0;
        for (int i = 0; i < MAX_DIG; i++) begin
            if (i < ndig - 1)
                r[4*i +: 4] = 4'd9;
            else if (i == ndig - 1)
                r[4*i +: 4] = bcd_digit_t'(top_max);
        end
        return r;
    endfunction

    // Adds or subtracts 10^pos with ripple carry/borrow across all MAX_DIG
    // digits. Callers pad unused upper digits with zero, so an overflow of the
    // real field shows up as a nonzero padded digit and an underflow as the
    // final borrow bit.
    function automatic bcd_ext_t bcd_ripple(input bcd_vec_t v, input int pos, input logic sub);
        bcd_vec_t   r;
        logic       c;
        logic [4:0] a;
        logic [4:0] d;
        logic [4:0] t;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < MAX_DIG; i++) begin
            a = ((i == pos) ? 5'd1 : 5'd0) + {4'd0, c};
            d = {1'b0, v[4*i +: 4]};
            if (sub) begin
                if (d < a) begin
                    t = d + 5'd10 - a;
                    c = 1'b1;
                end else begin
                    t = d - a;
                    c = 1'b0;
                end
            end else begin
                t = d + a;
                if (t > 5'd9) begin
                    t = t - 5'd10;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
            end
            r[4*i +: 4] = t[3:0];
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/bcd_field_editor_blink_timer.sv
// Cursor blink phase generator: free-running half-period counter that any
// accepted keypress restarts with the cursor visible.
module blink_timer #(
    parameter int BLINK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic blink
);

    localparam int              CNTW     = $clog2(BLINK_DIV);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLINK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [CNTW-1:0] cnt;

    // Count 0..BLINK_DIV-1, toggle on wrap; restart forces a fresh visible phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// Multi-digit BCD field editor: cursor, scrolling display window, per-digit
// wrap or decimal carry/borrow editing, parallel load and change strobe.
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int NDIG      = 5,
    parameter int WIN       = 4,
    parameter int BLINK_DIV = 12500000,
    parameter int TOP_MAX   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    carry_mode,
    input  logic                    left,
    input  logic                    right,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    load,
    input  logic [4*NDIG-1:0]       load_val,
    output logic [4*NDIG-1:0]       value,
    output logic [$clog2(NDIG)-1:0] curr,
    output logic [$clog2(NDIG)-1:0] p,
    output logic                    blink,
    output logic [5*WIN-1:0]        dout,
    output logic                    changed
);

    localparam int            CW      = $clog2(NDIG);
    localparam logic [CW-1:0] LAST    = CW'(NDIG - 1);
    localparam logic [CW-1:0] P_MAX   = CW'(NDIG - WIN);
    localparam logic [CW-1:0] WIN_M1  = CW'(WIN - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam bcd_digit_t    TOP_D   = bcd_digit_t'(TOP_MAX);
    localparam bcd_digit_t    NINE    = 4'd9;
    localparam bcd_ext_t      MAX_EXT = {1'b0, bcd_max(NDIG, TOP_MAX)};
    localparam logic [4*NDIG-1:0] MAX_VAL = MAX_EXT[4*NDIG-1:0];

    logic [4*NDIG-1:0] value_q, value_d;
    logic [CW-1:0]     curr_q, curr_d;
    logic [CW-1:0]     p_q, p_d;
    logic              changed_q;
    logic [5*WIN-1:0]  dout_q, dout_d;
    logic              restart;
    bcd_vec_t          vec_in;
    bcd_ext_t          rip;
    logic [4:0]        code;

    // Cursor keys are always live; inc/dec/load count only while editing is enabled.
    assign restart = left | right | (en & (inc | dec | load));

    blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .blink   (blink)
    );

    // Cursor move with window scroll; left wins when both keys arrive together.
    always_comb begin
        curr_d = curr_q;
        p_d    = p_q;
        if (left) begin
            if (curr_q == LAST) begin
                curr_d = '0;
                p_d    = '0;
            end else begin
                curr_d = curr_q + ONE;
                if (curr_q - p_q == WIN_M1)
                    p_d = p_q + ONE;
            end
        end else if (right) begin
            if (curr_q == '0) begin
                curr_d = LAST;
                p_d    = P_MAX;
            end else begin
                curr_d = curr_q - ONE;
                if (curr_q == p_q)
                    p_d = p_q - ONE;
            end
        end
    end

    // Value edit at the pre-move cursor: load beats inc beats dec.
    always_comb begin
        value_d = value_q;
        vec_in  = '0;
        vec_in[4*NDIG-1:0] = value_q;
        rip     = bcd_ripple(vec_in, int'(curr_q), ~inc);
        if (en) begin
            if (load) begin
                for (int i = 0; i < NDIG; i++)
                    value_d[4*i +: 4] = bcd_clamp(load_val[4*i +: 4], (i == NDIG - 1) ? TOP_D : NINE);
            end else if (inc || dec) begin
                if (carry_mode) begin
                    if (inc)
                        value_d = (rip > MAX_EXT) ? MAX_VAL : rip[4*NDIG-1:0];
                    else
                        value_d = rip[4*MAX_DIG] ? '0 : rip[4*NDIG-1:0];
                end else begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (i == int'(curr_q)) begin
                            if (inc)
                                value_d[4*i +: 4] = bcd_inc_wrap(value_q[4*i +: 4], (i == NDIG - 1) ? TOP_D : NINE);
                            else
                                value_d[4*i +: 4] = bcd_dec_wrap(value_q[4*i +: 4], (i == NDIG - 1) ? TOP_D : NINE);
                        end
                    end
                end
            end
        end
    end

    // Window codes from the registered state; the cursor digit blanks in the off phase.
    always_comb begin
        dout_d = '0;
        code   = '0;
        for (int i = 0; i < WIN; i++) begin
            code = '0;
            for (int j = 0; j < NDIG; j++) begin
                if (int'(p_q) + i == j)
                    code = {1'b0, value_q[4*j +: 4]};
            end
            if ((int'(p_q) + i == int'(curr_q)) && !blink)
                code = BLANK_CODE;
            dout_d[5*i +: 5] = code;
        end
    end

    // State, change strobe and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q   <= '0;
            curr_q    <= '0;
            p_q       <= '0;
            changed_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            value_q   <= value_d;
            curr_q    <= curr_d;
            p_q       <= p_d;
            changed_q <= (value_d != value_q);
            dout_q    <= dout_d;
        end
    end

    assign value   = value_q;
    assign curr    = curr_q;
    assign p       = p_q;
    assign changed = changed_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Self-checking bench for bcd_field_editor (NDIG=5, WIN=4, BLINK_DIV=4).
module tb_bcd_field_editor;

    localparam int NDIG      = 5;
    localparam int WIN       = 4;
    localparam int BLINK_DIV = 4;
    localparam int TOP_MAX   = 9;
    localparam int CW        = $clog2(NDIG);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0, carry_mode = 1'b0;
    logic              left = 1'b0, right = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0;
    logic [4*NDIG-1:0] load_val = '0;
    logic [4*NDIG-1:0] value;
    logic [CW-1:0]     curr, p;
    logic              blink, changed;
    logic [5*WIN-1:0]  dout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        l, r, i, d, ld, en, cm;
        logic [19:0] lv;
        logic [19:0] ev;
        int          ec, ep;
        logic        chg;
    } vec_t;

    typedef struct {
        int          row;
        logic [19:0] ev;
        int          ec, ep;
        logic        chg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    bcd_field_editor #(
        .NDIG(NDIG), .WIN(WIN), .BLINK_DIV(BLINK_DIV), .TOP_MAX(TOP_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .carry_mode (carry_mode),
        .left       (left),
        .right      (right),
        .inc        (inc),
        .dec        (dec),
        .load       (load),
        .load_val   (load_val),
        .value      (value),
        .curr       (curr),
        .p          (p),
        .blink      (blink),
        .dout       (dout),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic l, r, i, d, ld, e, cm,
                                input logic [19:0] lv, ev, input int ec, ep, input logic chg);
        vec_t v;
        v.l = l; v.r = r; v.i = i; v.d = d; v.ld = ld; v.en = e; v.cm = cm;
        v.lv = lv; v.ev = ev; v.ec = ec; v.ep = ep; v.chg = chg;
        return v;
    endfunction

    function automatic logic [19:0] exp_dout(input logic vis);
        logic [4:0] c3;
        c3 = vis ? 5'd1 : 5'd31;
        return {c3, 5'd2, 5'd3, 5'd4};
    endfunction

    task automatic drive(input vec_t v);
        left = v.l; right = v.r; inc = v.i; dec = v.d; load = v.ld;
        en = v.en; carry_mode = v.cm; load_val = v.lv;
    endtask

    task automatic keys_off();
        left = 1'b0; right = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        //            l r i d ld en cm  load_val     exp value    curr p chg
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 2,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 3,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 4,1,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 4,1,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 3,1,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 2,1,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 1,1,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0, 20'h00009, 20'h00009, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1,0, 20'h00000, 20'h00009, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0, 20'h00000, 20'h00000, 0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,0, 20'h00009, 20'h00009, 0,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,1, 20'h00000, 20'h00010, 0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,1, 20'h99999, 20'h99999, 0,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,1, 20'h00000, 20'h99999, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1, 20'h00000, 20'h99999, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1, 20'h00000, 20'h99999, 2,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,1, 20'h00000, 20'h00000, 2,0,1));
        vecs.push_back(mk(0,0,0,1,0, 1,1, 20'h00000, 20'h00000, 2,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0, 20'h00000, 20'h00000, 2,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0, 20'h12345, 20'h00000, 2,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 20'h00000, 20'h00000, 3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 2,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0, 20'h00000, 20'h00000, 1,0,0));
        vecs.push_back(mk(1,0,1,0,0, 1,0, 20'h00000, 20'h00010, 2,0,1));
        vecs.push_back(mk(1,1,0,0,0, 1,0, 20'h00000, 20'h00010, 3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 1,0, 20'h00000, 20'h09010, 3,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,0, 20'hFABC3, 20'h99993, 3,0,1));
        vecs.push_back(mk(0,0,0,1,0, 1,1, 20'h00000, 20'h98993, 3,0,1));
        vecs.push_back(mk(0,0,1,1,0, 1,0, 20'h00000, 20'h99993, 3,0,1));
        vecs.push_back(mk(0,0,1,0,1, 1,0, 20'h01234, 20'h01234, 3,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,1, 20'h00000, 20'h02234, 3,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,1, 20'h09999, 20'h09999, 3,0,1));
        vecs.push_back(mk(0,0,1,0,0, 1,1, 20'h00000, 20'h10999, 3,0,1));
        vecs.push_back(mk(0,0,0,1,0, 1,1, 20'h00000, 20'h09999, 3,0,1));
        vecs.push_back(mk(1,0,0,0,0, 1,1, 20'h00000, 20'h09999, 4,1,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0, 20'h00000, 20'h19999, 4,1,1));
        vecs.push_back(mk(0,0,0,0,1, 1,0, 20'h90000, 20'h90000, 4,1,1));
        vecs.push_back(mk(0,0,1,0,0, 1,0, 20'h00000, 20'h00000, 4,1,1));
        vecs.push_back(mk(0,0,0,1,0, 1,0, 20'h00000, 20'h90000, 4,1,1));
        vecs.push_back(mk(0,0,0,1,0, 1,1, 20'h00000, 20'h80000, 4,1,1));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset value",   32'(value),   32'h0);
        chk("reset curr",    32'(curr),    32'h0);
        chk("reset p",       32'(p),       32'h0);
        chk("reset blink",   32'(blink),   32'h0);
        chk("reset dout",    32'(dout),    32'h0);
        chk("reset changed", 32'(changed), 32'h0);

        // Table: one vector per cycle, back to back; results are due one edge later.
        rst = 1'b0;
        foreach (vecs[k]) begin
            drive(vecs[k]);
            e.row = k; e.ev = vecs[k].ev; e.ec = vecs[k].ec; e.ep = vecs[k].ep; e.chg = vecs[k].chg;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            chk($sformatf("row%0d value", e.row),   32'(value),   32'(e.ev));
            chk($sformatf("row%0d curr", e.row),    32'(curr),    32'(e.ec));
            chk($sformatf("row%0d p", e.row),       32'(p),       32'(e.ep));
            chk($sformatf("row%0d changed", e.row), 32'(changed), 32'(e.chg));
            chk($sformatf("row%0d blink", e.row),   32'(blink),   32'h1);
        end
        keys_off();
        en = 1'b0;
        carry_mode = 1'b0;

        // Blink sequence: value 01234, cursor on digit 3, window at 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            left = 1'b1;
            step();
        end
        left = 1'b0;
        en = 1'b1;
        load = 1'b1;
        load_val = 20'h01234;
        step();
        keys_off();
        chk("blink setup value", 32'(value), 32'h01234);
        chk("blink setup curr",  32'(curr),  32'd3);
        chk("blink setup p",     32'(p),     32'd0);
        chk("blink k0",          32'(blink), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("idle blink k%0d", k), 32'(blink), 32'((k < 4) ? 1 : 0));
            chk($sformatf("idle dout k%0d", k),  32'(dout),  32'(exp_dout((k - 1) < 4)));
        end
        // Same-value load mid off-phase: restarts blink, no change strobe.
        load = 1'b1;
        load_val = 20'h01234;
        step();
        keys_off();
        chk("restart blink m0",   32'(blink),   32'h1);
        chk("restart changed m0", 32'(changed), 32'h0);
        chk("restart dout m0",    32'(dout),    32'(exp_dout(1'b0)));
        for (int m = 1; m <= 5; m++) begin
            step();
            chk($sformatf("restart blink m%0d", m), 32'(blink), 32'((m < 4) ? 1 : 0));
            chk($sformatf("restart dout m%0d", m),  32'(dout),  32'(exp_dout((m - 1) < 4)));
        end

        // Asynchronous reset mid-edit, checked before the next rising edge.
        #1;
        rst = 1'b1;
        #1;
        chk("async value",   32'(value),   32'h0);
        chk("async curr",    32'(curr),    32'h0);
        chk("async p",       32'(p),       32'h0);
        chk("async blink",   32'(blink),   32'h0);
        chk("async dout",    32'(dout),    32'h0);
        chk("async changed", 32'(changed), 32'h0);

        // First edge after reset release accepts an edit.
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        carry_mode = 1'b0;
        inc = 1'b1;
        left = 1'b1;
        step();
        keys_off();
        chk("post-reset value",   32'(value),   32'h00001);
        chk("post-reset curr",    32'(curr),    32'd1);
        chk("post-reset changed", 32'(changed), 32'h1);
        chk("post-reset blink",   32'(blink),   32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
